// File: rtl/vis_serialiser_pkg.sv
// Shared constants, byte-count helpers and FSM encoding for the visibility serialiser.
package vis_serialiser_pkg;

  localparam int unsigned VIS_WIDTH = 36;
  localparam logic [7:0]  HDR_SYNC0 = 8'hA5;
  localparam logic [7:0]  HDR_SYNC1 = 8'h5A;
  localparam int unsigned HDR_BYTES = 4;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData
  } state_e;

  function automatic int unsigned vbytes(input int unsigned width);
    return (width + 7) / 8;
  endfunction

  function automatic int unsigned pbytes(input int unsigned width);
    return 2 * vbytes(width);
  endfunction

endpackage

// File: rtl/vis_serialiser_if.sv
// Input pair handshake and output byte stream of the visibility serialiser.
interface vis_serialiser_if
  import vis_serialiser_pkg::*;
#(
  parameter int unsigned WIDTH = VIS_WIDTH
);
  logic             s_valid_i;
  logic             s_ready_o;
  logic             s_last_i;
  logic [WIDTH-1:0] revis_i;
  logic [WIDTH-1:0] imvis_i;
  logic             m_tvalid_o;
  logic             m_tready_i;
  logic             m_tlast_o;
  logic [7:0]       m_tdata_o;

  modport slave (
    input  s_valid_i, s_last_i, revis_i, imvis_i, m_tready_i,
    output s_ready_o, m_tvalid_o, m_tlast_o, m_tdata_o
  );

  modport master (
    output s_valid_i, s_last_i, revis_i, imvis_i, m_tready_i,
    input  s_ready_o, m_tvalid_o, m_tlast_o, m_tdata_o
  );
endinterface

// File: rtl/vis_fifo.sv
// Synchronous first-word fall-through FIFO with full/empty flags and occupancy count.
module vis_fifo #(
  parameter int unsigned W     = 73,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ABITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [W-1:0]   wdata,
  input  logic           pop,
  output logic [W-1:0]   rdata,
  output logic           full,
  output logic           empty,
  output logic [ABITS:0] level
);
  logic [W-1:0]     mem [DEPTH];
  logic [ABITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [ABITS:0]   level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == (ABITS+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/vis_serialiser.sv
// Buffers (real, imag) visibility pairs and streams them out as little-endian bytes.
// Define VIS_SERIALISER_HEADER_EN to prefix each frame with a 4-byte sync/frame-count header.
module vis_serialiser
  import vis_serialiser_pkg::*;
#(
  parameter int unsigned WIDTH = VIS_WIDTH,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ABITS = 4
) (
  input  logic           clock_i,
  input  logic           reset_i,
  vis_serialiser_if.slave bus,
  output logic [ABITS:0] level_o
);
  localparam int unsigned VB = vbytes(WIDTH);
  localparam int unsigned PB = pbytes(WIDTH);
  localparam int unsigned FW = 2 * WIDTH + 1;
  localparam int unsigned CW = ($clog2(PB) < 2) ? 2 : $clog2(PB);
  localparam logic [CW-1:0] CntLast = CW'(PB - 1);
`ifdef VIS_SERIALISER_HEADER_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PB*8-1:0]   shreg_q, shreg_d;
  logic              last_q, last_d;
  logic              load, tvalid, tlast;
  logic [7:0]        tdata;
  logic [FW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [VB*8-1:0]   re_ext, im_ext;

  vis_fifo #(
    .W     (FW),
    .DEPTH (DEPTH),
    .ABITS (ABITS)
  ) u_fifo (
    .clk   (clock_i),
    .rst   (reset_i),
    .push  (bus.s_valid_i),
    .wdata ({bus.s_last_i, bus.imvis_i, bus.revis_i}),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  always_comb begin
    re_ext = '0;
    im_ext = '0;
    re_ext[WIDTH-1:0] = fifo_rdata[WIDTH-1:0];
    im_ext[WIDTH-1:0] = fifo_rdata[2*WIDTH-1:WIDTH];
  end

`ifdef VIS_SERIALISER_HEADER_EN
  logic [15:0] frame_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      frame_q <= '0;
    end else if (tvalid && bus.m_tready_i && tlast) begin
      frame_q <= frame_q + 16'd1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    load    = 1'b0;
    tvalid  = 1'b0;
    tdata   = 8'h00;
    tlast   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = (HdrEn && last_q) ? StHdr : StData;
        end
      end
`ifdef VIS_SERIALISER_HEADER_EN
      StHdr: begin
        tvalid = 1'b1;
        case (cnt_q[1:0])
          2'd0:    tdata = HDR_SYNC0;
          2'd1:    tdata = HDR_SYNC1;
          2'd2:    tdata = frame_q[7:0];
          default: tdata = frame_q[15:8];
        endcase
        if (bus.m_tready_i) begin
          if (cnt_q == CW'(HDR_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = StData;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      StData: begin
        tvalid = 1'b1;
        tdata  = shreg_q[7:0];
        tlast  = last_q && (cnt_q == CntLast);
        if (bus.m_tready_i) begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            // Reload in the same cycle so back-to-back pairs have no bubble.
            if (!fifo_empty) begin
              load    = 1'b1;
              state_d = (HdrEn && last_q) ? StHdr : StData;
            end else begin
              state_d = StIdle;
            end
          end else begin
            shreg_d = shreg_q >> 8;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      shreg_d = {im_ext, re_ext};
      last_d  = fifo_rdata[FW-1];
    end
  end

  // last_q also means "next pair opens a frame", hence it resets high.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
    end
  end

  assign bus.s_ready_o  = !fifo_full;
  assign bus.m_tvalid_o = tvalid;
  assign bus.m_tdata_o  = tdata;
  assign bus.m_tlast_o  = tlast;
endmodule

// File: tb/tb_vis_serialiser.sv
// Directed self-checking bench for vis_serialiser; follows VIS_SERIALISER_HEADER_EN if defined.
module tb_vis_serialiser;
  localparam int unsigned WIDTH = 36;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned ABITS = 4;
`ifdef VIS_SERIALISER_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [ABITS:0] level;

  vis_serialiser_if #(.WIDTH(WIDTH)) bus ();

  vis_serialiser #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ABITS (ABITS)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus),
    .level_o (level)
  );

  always #5 clk = ~clk;

  int          n_chk, n_fail, valid_cnt, n_acc, level_max;
  logic [8:0]  exp_q[$];
  bit          stall_pend, auto_exp, m_sof;
  logic [7:0]  stall_data;
  logic        stall_last;
  logic [15:0] m_frame;
  logic [7:0]  t1 [10];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] b, input logic l);
    exp_q.push_back({l, b});
  endtask

  task automatic push_hdr(input logic [15:0] f);
    push_exp(8'hA5, 1'b0);
    push_exp(8'h5A, 1'b0);
    push_exp(f[7:0], 1'b0);
    push_exp(f[15:8], 1'b0);
  endtask

  // Reference: header on frame start, then real LE, then imag LE (40 bits each).
  task automatic model_pair(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im,
                            input logic last);
    logic [39:0] r, i;
    r = 40'(re);
    i = 40'(im);
    if (HDR_EN && m_sof) push_hdr(m_frame);
    for (int k = 0; k < 5; k++) push_exp(r[8*k +: 8], 1'b0);
    for (int k = 0; k < 5; k++) push_exp(i[8*k +: 8], (k == 4) && last);
    if (last) m_frame = m_frame + 16'd1;
    m_sof = last;
  endtask

  task automatic set_pair(input int i, input logic last);
    bus.revis_i  = 36'(64'h0_1000_0003 * 64'(i + 1));
    bus.imvis_i  = 36'(64'h0_A5C3_0101 ^ 64'(i * 77));
    bus.s_last_i = last;
  endtask

  // One clock: check this cycle's outputs, record handshakes, then advance.
  task automatic clk_step();
    logic [8:0] e;
    #1;
    if (stall_pend) begin
      check("hold_valid", bus.m_tvalid_o, 1);
      check("hold_data", bus.m_tdata_o, stall_data);
      check("hold_last", bus.m_tlast_o, stall_last);
    end
    if (bus.m_tvalid_o === 1'b1 && bus.m_tready_i === 1'b1) begin
      valid_cnt++;
      check("byte_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("byte_data", bus.m_tdata_o, e[7:0]);
        check("byte_last", bus.m_tlast_o, e[8]);
      end
    end
    stall_pend = (bus.m_tvalid_o === 1'b1) && (bus.m_tready_i === 1'b0);
    stall_data = bus.m_tdata_o;
    stall_last = bus.m_tlast_o;
    if (bus.s_valid_i === 1'b1 && bus.s_ready_o === 1'b1) begin
      n_acc++;
      if (auto_exp) model_pair(bus.revis_i, bus.imvis_i, bus.s_last_i);
    end
    if (int'(level) > level_max) level_max = int'(level);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.s_valid_i  = 1'b0;
    bus.m_tready_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tvalid", bus.m_tvalid_o, 0);
    check("rst_tlast", bus.m_tlast_o, 0);
    check("rst_tdata", bus.m_tdata_o, 0);
    check("rst_ready", bus.s_ready_o, 1);
    check("rst_level", level, 0);
    rst = 1'b0;
    stall_pend = 1'b0;
    exp_q.delete();
    m_sof   = 1'b1;
    m_frame = 16'd0;
  endtask

  task automatic wait_valid(input int budget);
    int c;
    c = 0;
    while (bus.m_tvalid_o !== 1'b1 && c < budget) begin
      clk_step();
      c++;
    end
    check("wait_valid", bus.m_tvalid_o, 1);
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      clk_step();
      c++;
    end
    check("drain_left", exp_q.size(), 0);
    clk_step();
    check("drain_idle", bus.m_tvalid_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, base, c;
    n_chk = 0; n_fail = 0; valid_cnt = 0; n_acc = 0; level_max = 0;
    auto_exp = 1'b1; stall_pend = 1'b0; m_sof = 1'b1; m_frame = 16'd0;
    bus.s_valid_i = 1'b0; bus.s_last_i = 1'b0; bus.m_tready_i = 1'b0;
    bus.revis_i = '0; bus.imvis_i = '0;
    t1 = '{8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h0A};
    do_reset();

    // Single pair: first byte two cycles after acceptance, hand-computed order.
    auto_exp = 1'b0;
    if (HDR_EN) push_hdr(16'h0000);
    for (int k = 0; k < 10; k++) push_exp(t1[k], k == 9);
    bus.revis_i = 36'h1_2345_6789; bus.imvis_i = 36'hA_BCDE_F012; bus.s_last_i = 1'b1;
    bus.s_valid_i = 1'b1; bus.m_tready_i = 1'b1;
    check("t1_ready", bus.s_ready_o, 1);
    clk_step();
    bus.s_valid_i = 1'b0;
    check("t1_valid_n1", bus.m_tvalid_o, 0);
    check("t1_level_n1", level, 1);
    clk_step();
    check("t1_valid_n2", bus.m_tvalid_o, 1);
    valid_cnt = 0;
    repeat (HDR_EN ? 14 : 10) clk_step();
    check("t1_count", valid_cnt, HDR_EN ? 14 : 10);
    check("t1_idle", bus.m_tvalid_o, 0);
    check("t1_level_end", level, 0);
    m_sof = 1'b1; m_frame = 16'd1; auto_exp = 1'b1;

    // Back-to-back: three pairs, no bubble, occupancy peaks at 2.
    valid_cnt = 0; level_max = 0;
    for (int i = 0; i < 3; i++) begin
      set_pair(i, i == 2);
      bus.s_valid_i = 1'b1;
      clk_step();
    end
    bus.s_valid_i = 1'b0;
    repeat (HDR_EN ? 33 : 29) clk_step();
    check("t2_bytes", valid_cnt, HDR_EN ? 34 : 30);
    check("t2_level_peak", level_max, 2);
    check("t2_left", exp_q.size(), 0);
    check("t2_idle", bus.m_tvalid_o, 0);

    // Backpressure: 20 pairs offered with the sink stalled.
    bus.m_tready_i = 1'b0; base = n_acc; idx = 0;
    for (int k = 0; k < 25; k++) begin
      set_pair(10 + idx, (idx % 5) == 4);
      bus.s_valid_i = 1'b1;
      clk_step();
      idx = n_acc - base;
    end
    check("t3_level_full", level, 16);
    check("t3_ready_low", bus.s_ready_o, 0);
    check("t3_accepted", idx, 17);
    bus.m_tready_i = 1'b1; c = 0;
    while (idx < 20 && c < 200) begin
      set_pair(10 + idx, (idx % 5) == 4);
      bus.s_valid_i = 1'b1;
      clk_step();
      idx = n_acc - base;
      c++;
    end
    bus.s_valid_i = 1'b0;
    check("t3_all_accepted", idx, 20);
    drain(400);

    // Output stall on the third byte.
    set_pair(40, 1'b1);
    bus.s_valid_i = 1'b1; bus.m_tready_i = 1'b1;
    clk_step();
    bus.s_valid_i = 1'b0;
    wait_valid(10);
    clk_step();
    clk_step();
    bus.m_tready_i = 1'b0;
    #1;
    check("t4_stall_data", bus.m_tdata_o, exp_q[0][7:0]);
    clk_step();
    clk_step();
    bus.m_tready_i = 1'b1;
    drain(50);

    // Reset mid-pair with two pairs queued.
    valid_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      set_pair(50 + i, i == 2);
      bus.s_valid_i = 1'b1;
      clk_step();
    end
    bus.s_valid_i = 1'b0; c = 0;
    while (valid_cnt < 4 && c < 20) begin
      clk_step();
      c++;
    end
    check("t5_bytes_sent", valid_cnt, 4);
    check("t5_queued", level, 2);
    do_reset();
    set_pair(60, 1'b1);
    bus.s_valid_i = 1'b1; bus.m_tready_i = 1'b1;
    clk_step();
    bus.s_valid_i = 1'b0;
    wait_valid(10);
    drain(50);

    // Two single-pair frames after reset; frame counter 0 then 1 in headers.
    do_reset();
    auto_exp = 1'b0;
    for (int f = 0; f < 2; f++) begin
      if (HDR_EN) push_hdr(16'(f));
      for (int k = 0; k < 10; k++) push_exp(t1[k], k == 9);
    end
    bus.revis_i = 36'h1_2345_6789; bus.imvis_i = 36'hA_BCDE_F012; bus.s_last_i = 1'b1;
    bus.s_valid_i = 1'b1; bus.m_tready_i = 1'b1;
    clk_step();
    clk_step();
    bus.s_valid_i = 1'b0;
    drain(100);
    auto_exp = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
